// File: rtl/text_pkg.sv
// ---------------------------------------------------------------------------
// text_pkg
// Shared constants and types for the text-screen write engine: screen
// geometry, the control codes the writer interprets, the writer FSM state
// enum and the RAM cell address packing helper.
// ---------------------------------------------------------------------------
package text_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 60;
    localparam int COL_W  = 7;
    localparam int ROW_W  = 6;
    localparam int ADDR_W = ROW_W + COL_W + 1;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    // Attribute written by clears: white foreground, black background.
    localparam logic [7:0] DEFAULT_META = 8'h07;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        WR_ASCII,
        WR_META,
        CLR_ROW,
        CLR_ALL
    } writer_state_e;

    // RAM address layout: {row, col, sel}; sel 0 = ASCII byte, 1 = meta byte.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col,
                                                    input logic             sel);
        return {row, col, sel};
    endfunction

endpackage

// File: rtl/text_cursor.sv
// ---------------------------------------------------------------------------
// text_cursor
// Hardware cursor (column/row registers) for the text writer.
// Ports:
//   clk_25, reset          clock, asynchronous active-high reset
//   cmd_inc                advance one cell, wrapping to the next row at the end
//   cmd_wrap               line feed: column 0, next row
//   cmd_back               backspace: column - 1, stops at column 0
//   cmd_home               column 0, row 0
//   cmd_cr                 carriage return: column 0
//   col, row               current cursor position
//   row_next               row the cursor will hold after this cycle's command
//   last_col               cursor is in the last column
// Commands are mutually exclusive in normal use; home has priority.
// ---------------------------------------------------------------------------
module text_cursor
    import text_pkg::*;
(
    input  logic             clk_25,
    input  logic             reset,
    input  logic             cmd_inc,
    input  logic             cmd_wrap,
    input  logic             cmd_back,
    input  logic             cmd_home,
    input  logic             cmd_cr,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic [ROW_W-1:0] row_next,
    output logic             last_col
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             last_row;
    logic [ROW_W-1:0] row_wrapped;

    assign last_col    = (col_q == LAST_COL);
    assign last_row    = (row_q == LAST_ROW);
    // No scrolling: moving past the bottom row lands on row 0.
    assign row_wrapped = last_row ? '0 : row_q + 1'b1;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        col_d = col_q;
        row_d = row_q;
        if (cmd_home) begin
            col_d = '0;
            row_d = '0;
        end else if (cmd_wrap) begin
            col_d = '0;
            row_d = row_wrapped;
        end else if (cmd_inc) begin
            if (last_col) begin
                col_d = '0;
                row_d = row_wrapped;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (cmd_back) begin
            if (col_q != '0) begin
                col_d = col_q - 1'b1;
            end
        end else if (cmd_cr) begin
            col_d = '0;
        end
    end

    always_ff @(posedge clk_25 or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col      = col_q;
    assign row      = row_q;
    assign row_next = row_d;

endmodule

// File: rtl/text_writer.sv
// ---------------------------------------------------------------------------
// text_writer
// Write-side engine for the 80x60 text screen RAM. Accepts ASCII + meta
// bytes over valid/ready, writes them at the cursor and interprets CR, LF,
// BS and FF. Entering a new row (LF or auto-wrap) blanks that row; FF
// blanks the whole screen and homes the cursor.
// Ports:
//   clk_25, reset          clock, asynchronous active-high reset
//   char_in, meta_in       character code and attribute (meta bit 7 dropped)
//   char_valid/char_ready  input handshake; ready only while IDLE
//   ram_addr/data/wr_en    registered RAM write port, {row,col,sel} address
//   cursor_col/cursor_row  current cursor position
//   busy                   not IDLE (inverse of char_ready)
// ---------------------------------------------------------------------------
module text_writer
    import text_pkg::*;
(
    input  logic        clk_25,
    input  logic        reset,
    input  logic [7:0]  char_in,
    input  logic [7:0]  meta_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [13:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        ram_wr_en,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row,
    output logic        busy
);

    writer_state_e state_q, state_d;

    logic [7:0]        meta_q, meta_d;
    logic [COL_W-1:0]  clr_col_q, clr_col_d;
    logic [ROW_W-1:0]  clr_row_q, clr_row_d;
    logic              clr_sel_q, clr_sel_d;

    logic              ram_wr_en_q, ram_wr_en_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_data_q, ram_data_d;

    logic              accept;
    logic              sweep_row_end;
    logic              clearing;

    logic              cur_inc, cur_wrap, cur_back, cur_home, cur_cr;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row, cur_row_next;
    logic              cur_last_col;

    text_cursor u_cursor (
        .clk_25   (clk_25),
        .reset    (reset),
        .cmd_inc  (cur_inc),
        .cmd_wrap (cur_wrap),
        .cmd_back (cur_back),
        .cmd_home (cur_home),
        .cmd_cr   (cur_cr),
        .col      (cur_col),
        .row      (cur_row),
        .row_next (cur_row_next),
        .last_col (cur_last_col)
    );

    assign accept        = char_valid && (state_q == IDLE);
    assign clearing      = (state_q == CLR_ROW) || (state_q == CLR_ALL);
    // The port is currently writing the meta byte of the last column.
    assign sweep_row_end = (clr_col_q == LAST_COL) && clr_sel_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            meta_q      <= '0;
            clr_col_q   <= '0;
            clr_row_q   <= '0;
            clr_sel_q   <= 1'b0;
            ram_wr_en_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            meta_q      <= meta_d;
            clr_col_q   <= clr_col_d;
            clr_row_q   <= clr_row_d;
            clr_sel_q   <= clr_sel_d;
            ram_wr_en_q <= ram_wr_en_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (char_in)
                        CH_CR, CH_BS: state_d = IDLE;
                        CH_LF:        state_d = CLR_ROW;
                        CH_FF:        state_d = CLR_ALL;
                        default:      state_d = WR_ASCII;
                    endcase
                end
            end
            WR_ASCII: state_d = WR_META;
            // Writing into the last column wraps onto a fresh row to blank.
            WR_META:  state_d = cur_last_col ? CLR_ROW : IDLE;
            CLR_ROW:  if (sweep_row_end) state_d = IDLE;
            CLR_ALL:  if (sweep_row_end && (clr_row_q == LAST_ROW)) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        cur_inc     = 1'b0;
        cur_wrap    = 1'b0;
        cur_back    = 1'b0;
        cur_home    = 1'b0;
        cur_cr      = 1'b0;
        meta_d      = meta_q;
        clr_col_d   = '0;
        clr_row_d   = '0;
        clr_sel_d   = 1'b0;
        ram_wr_en_d = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;

        // Cursor commands.
        case (state_q)
            IDLE: begin
                if (accept) begin
                    meta_d = meta_in & 8'h7F;
                    case (char_in)
                        CH_CR:   cur_cr   = 1'b1;
                        CH_BS:   cur_back = 1'b1;
                        CH_LF:   cur_wrap = 1'b1;
                        default: ;
                    endcase
                end
            end
            WR_META: cur_inc = 1'b1;
            CLR_ALL: cur_home = (state_d == IDLE);
            default: ;
        endcase

        // Sweep counters track the cell on the port; they rest at zero
        // outside a sweep so each sweep starts from column 0, sel 0.
        if (clearing) begin
            clr_col_d = clr_col_q;
            clr_row_d = clr_row_q;
            clr_sel_d = ~clr_sel_q;
            if (clr_sel_q) begin
                if (clr_col_q == LAST_COL) begin
                    clr_col_d = '0;
                    clr_row_d = (clr_row_q == LAST_ROW) ? '0 : clr_row_q + 1'b1;
                end else begin
                    clr_col_d = clr_col_q + 1'b1;
                end
            end
        end

        // The RAM port is loaded with the write belonging to the next state.
        case (state_d)
            WR_ASCII: begin
                ram_wr_en_d = 1'b1;
                ram_addr_d  = cell_addr(cur_row, cur_col, 1'b0);
                ram_data_d  = char_in;
            end
            WR_META: begin
                ram_wr_en_d = 1'b1;
                ram_addr_d  = cell_addr(cur_row, cur_col, 1'b1);
                ram_data_d  = meta_q;
            end
            CLR_ROW: begin
                ram_wr_en_d = 1'b1;
                ram_addr_d  = cell_addr(cur_row_next, clr_col_d, clr_sel_d);
                ram_data_d  = clr_sel_d ? DEFAULT_META : CH_SPACE;
            end
            CLR_ALL: begin
                ram_wr_en_d = 1'b1;
                ram_addr_d  = cell_addr(clr_row_d, clr_col_d, clr_sel_d);
                ram_data_d  = clr_sel_d ? DEFAULT_META : CH_SPACE;
            end
            default: ;
        endcase
    end

    assign char_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign ram_wr_en  = ram_wr_en_q;
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign cursor_col = cur_col;
    assign cursor_row = cur_row;

endmodule
